// File: rtl/video_timing_gen_pkg.sv
// Shared XGA timing defaults, sync-bit layout and a small sizing helper.
package video_timing_pkg;

  localparam int unsigned CNT_W        = 12;
  localparam int unsigned MAX_TOTAL    = 4096;
  localparam int unsigned SYNC_DLY_MIN = 1;
  localparam int unsigned SYNC_DLY_MAX = 7;

  localparam int unsigned XGA_H_ACTIVE = 1024;
  localparam int unsigned XGA_H_FP     = 24;
  localparam int unsigned XGA_H_SYNC   = 136;
  localparam int unsigned XGA_H_BP     = 160;
  localparam int unsigned XGA_V_ACTIVE = 768;
  localparam int unsigned XGA_V_FP     = 3;
  localparam int unsigned XGA_V_SYNC   = 6;
  localparam int unsigned XGA_V_BP     = 29;
  localparam logic        XGA_HS_POL   = 1'b0;
  localparam logic        XGA_VS_POL   = 1'b0;

  // Bit order of the delayed sync bundle.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  function automatic int unsigned total(input int unsigned a, input int unsigned b,
                                        input int unsigned c, input int unsigned d);
    return a + b + c + d;
  endfunction

  localparam int unsigned XGA_H_TOTAL = total(XGA_H_ACTIVE, XGA_H_FP, XGA_H_SYNC, XGA_H_BP);
  localparam int unsigned XGA_V_TOTAL = total(XGA_V_ACTIVE, XGA_V_FP, XGA_V_SYNC, XGA_V_BP);

endpackage

// File: rtl/video_timing_gen_sync_delay_line.sv
// Fixed-depth shift register that realigns hsync/vsync/de with renderer output.
module sync_delay_line #(
  parameter int unsigned            WIDTH     = 3,
  parameter int unsigned            DEPTH     = 2,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;
  logic [DEPTH-1:0][WIDTH-1:0] pipe_d;

  // Shift one stage per clock; stage 0 takes the new sample.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = i_d;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Whole line reloads the idle value on reset so no stale sync leaks out.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pipe_q <= {DEPTH{RESET_VAL}};
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign o_q = pipe_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Raster counters, line/frame pulses and delayed hsync/vsync/de decode.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = XGA_H_ACTIVE,
  parameter int unsigned H_FP     = XGA_H_FP,
  parameter int unsigned H_SYNC   = XGA_H_SYNC,
  parameter int unsigned H_BP     = XGA_H_BP,
  parameter int unsigned V_ACTIVE = XGA_V_ACTIVE,
  parameter int unsigned V_FP     = XGA_V_FP,
  parameter int unsigned V_SYNC   = XGA_V_SYNC,
  parameter int unsigned V_BP     = XGA_V_BP,
  parameter logic        HS_POL   = XGA_HS_POL,
  parameter logic        VS_POL   = XGA_VS_POL,
  parameter int unsigned SYNC_DLY = 2
) (
  input  logic             i_clk_74M,
  input  logic             i_rst_n,
  output logic [CNT_W-1:0] o_hcnt,
  output logic [CNT_W-1:0] o_vcnt,
  output logic             o_line_start,
  output logic             o_frame_start,
  output logic             o_hsync,
  output logic             o_vsync,
  output logic             o_de
);

  localparam int unsigned H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned EXT_W   = CNT_W + 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  // Decode bounds carry one extra bit so an end value of 4096 stays exact.
  localparam logic [EXT_W-1:0] H_DE_END  = EXT_W'(H_ACTIVE);
  localparam logic [EXT_W-1:0] V_DE_END  = EXT_W'(V_ACTIVE);
  localparam logic [EXT_W-1:0] H_HS_BEG  = EXT_W'(H_ACTIVE + H_FP);
  localparam logic [EXT_W-1:0] H_HS_END  = EXT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [EXT_W-1:0] V_VS_BEG  = EXT_W'(V_ACTIVE + V_FP);
  localparam logic [EXT_W-1:0] V_VS_END  = EXT_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam sync_bits_t IDLE_SYNC = '{hs: ~HS_POL, vs: ~VS_POL, de: 1'b0};

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
  end
  if (SYNC_DLY < SYNC_DLY_MIN || SYNC_DLY > SYNC_DLY_MAX) begin : g_bad_dly
    $error("video_timing_gen: SYNC_DLY must be within 1..7");
  end

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  sync_bits_t       sync_raw;
  logic [2:0]       sync_dly;
  sync_bits_t       sync_out;

  // Next raster position; pulses are computed one cycle early so they land with the 0 they flag.
  always_comb begin
    hcnt_d        = hcnt_q + 1'b1;
    vcnt_d        = vcnt_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (hcnt_q == H_LAST) begin
      hcnt_d       = '0;
      line_start_d = 1'b1;
      if (vcnt_q == V_LAST) begin
        vcnt_d        = '0;
        frame_start_d = 1'b1;
      end else begin
        vcnt_d = vcnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers; reset drops straight back to (0,0) with no pulse.
  always_ff @(posedge i_clk_74M) begin
    if (!i_rst_n) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Raw sync/de decode from the undelayed counters; vsync follows vcnt so its edges sit on hcnt = 0.
  always_comb begin
    sync_raw.de = ({1'b0, hcnt_q} < H_DE_END) && ({1'b0, vcnt_q} < V_DE_END);
    sync_raw.hs = (({1'b0, hcnt_q} >= H_HS_BEG) && ({1'b0, hcnt_q} < H_HS_END)) ? HS_POL : ~HS_POL;
    sync_raw.vs = (({1'b0, vcnt_q} >= V_VS_BEG) && ({1'b0, vcnt_q} < V_VS_END)) ? VS_POL : ~VS_POL;
  end

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (SYNC_DLY),
    .RESET_VAL(IDLE_SYNC)
  ) u_sync_dly (
    .i_clk  (i_clk_74M),
    .i_rst_n(i_rst_n),
    .i_d    (sync_raw),
    .o_q    (sync_dly)
  );

  assign sync_out      = sync_dly;
  assign o_hcnt        = hcnt_q;
  assign o_vcnt        = vcnt_q;
  assign o_line_start  = line_start_q;
  assign o_frame_start = frame_start_q;
  assign o_hsync       = sync_out.hs;
  assign o_vsync       = sync_out.vs;
  assign o_de          = sync_out.de;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster (32 x 17) so whole frames fit in a short run.
module tb_video_timing_gen;

  localparam int HA = 20, HFP = 3, HSW = 5, HBP = 4;
  localparam int VA = 10, VFP = 2, VSW = 3, VBP = 2;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int DLY = 2;

  logic        clk;
  logic        rst_n;
  logic [11:0] o_hcnt, o_vcnt;
  logic        o_line_start, o_frame_start, o_hsync, o_vsync, o_de;

  int checks = 0;
  int failures = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DLY(DLY)
  ) dut (
    .i_clk_74M    (clk),
    .i_rst_n      (rst_n),
    .o_hcnt       (o_hcnt),
    .o_vcnt       (o_vcnt),
    .o_line_start (o_line_start),
    .o_frame_start(o_frame_start),
    .o_hsync      (o_hsync),
    .o_vsync      (o_vsync),
    .o_de         (o_de)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: the whole DUT state is a function of the number of clocks since the last reset edge.
  int steps = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      steps = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      steps = steps + 1;
    end
  end

  // Returns {hsync, vsync, de} levels for the raster position reached after s clocks.
  function automatic logic [2:0] raw_levels(input int s);
    int pos, h, v;
    logic hs, vs, de;
    pos = s % FRAME;
    h = pos % HT;
    v = pos / HT;
    de = (h < HA) && (v < VA);
    hs = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    vs = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    return {hs, vs, de};
  endfunction

  always @(negedge clk) begin : compare
    int pos;
    logic [2:0] lv;
    if (model_valid) begin
      pos = steps % FRAME;
      lv = (steps >= DLY) ? raw_levels(steps - DLY) : 3'b110;
      check("m_hcnt", 32'(o_hcnt), 32'(pos % HT));
      check("m_vcnt", 32'(o_vcnt), 32'(pos / HT));
      check("m_line_start", 32'(o_line_start), 32'((steps > 0) && (pos % HT == 0)));
      check("m_frame_start", 32'(o_frame_start), 32'((steps > 0) && (pos == 0)));
      check("m_hsync", 32'(o_hsync), 32'(lv[2]));
      check("m_vsync", 32'(o_vsync), 32'(lv[1]));
      check("m_de", 32'(o_de), 32'(lv[0]));
    end
  end

  initial begin : driver
    int first_ls, first_hs, first_vs, first_de;
    int hs_line, de_line, de_frame, hs_frame, vs_frame, ls_frame, fs_quiet;
    int fs_e[$];
    first_ls = -1; first_hs = -1; first_vs = -1; first_de = -1;
    hs_line = 0; de_line = 0; de_frame = 0; hs_frame = 0; vs_frame = 0; ls_frame = 0; fs_quiet = 0;

    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_hcnt", 32'(o_hcnt), 0);
    check("rst_vcnt", 32'(o_vcnt), 0);
    check("rst_hsync", 32'(o_hsync), 1);
    check("rst_vsync", 32'(o_vsync), 1);
    check("rst_de", 32'(o_de), 0);
    check("rst_line_start", 32'(o_line_start), 0);
    check("rst_frame_start", 32'(o_frame_start), 0);
    rst_n = 1'b1;

    for (int e = 1; e <= 2 * FRAME; e++) begin
      @(negedge clk);
      if (e == 31) check("hcnt_line_end", 32'(o_hcnt), 31);
      if (e == 32) begin
        check("hcnt_wrap", 32'(o_hcnt), 0);
        check("vcnt_step", 32'(o_vcnt), 1);
      end
      if (o_line_start && first_ls < 0) first_ls = e;
      if (!o_hsync && first_hs < 0) first_hs = e;
      if (!o_vsync && first_vs < 0) first_vs = e;
      if (o_de && first_de < 0) first_de = e;
      if (o_frame_start) fs_e.push_back(e);
      if (e >= 33 && e <= 64) begin
        hs_line += int'(!o_hsync);
        de_line += int'(o_de);
      end
      if (e > FRAME) begin
        de_frame += int'(o_de);
        hs_frame += int'(!o_hsync);
        vs_frame += int'(!o_vsync);
        ls_frame += int'(o_line_start);
      end
    end
    check("first_line_start", first_ls, 32);
    check("hsync_fall", first_hs, 25);
    check("vsync_fall", first_vs, 386);
    check("de_rise", first_de, 2);
    check("hsync_per_line", hs_line, 5);
    check("de_per_line", de_line, 20);
    check("de_per_frame", de_frame, 200);
    check("hsync_per_frame", hs_frame, 85);
    check("vsync_per_frame", vs_frame, 96);
    check("line_starts_per_frame", ls_frame, 17);
    check("frame_start_count", fs_e.size(), 2);
    if (fs_e.size() == 2) begin
      check("frame_start_first", fs_e[0], 544);
      check("frame_start_period", fs_e[1] - fs_e[0], 544);
    end

    // One-cycle reset in the middle of a frame at (7,5).
    repeat (167) @(negedge clk);
    check("mid_pos_h", 32'(o_hcnt), 7);
    check("mid_pos_v", 32'(o_vcnt), 5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_hcnt", 32'(o_hcnt), 0);
    check("mid_rst_vcnt", 32'(o_vcnt), 0);
    check("mid_rst_hsync", 32'(o_hsync), 1);
    check("mid_rst_vsync", 32'(o_vsync), 1);
    check("mid_rst_de", 32'(o_de), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_hcnt", 32'(o_hcnt), 1);
    check("mid_rel_de_low", 32'(o_de), 0);
    @(negedge clk);
    check("mid_rel_de_high", 32'(o_de), 1);
    for (int i = 3; i <= 543; i++) begin
      @(negedge clk);
      fs_quiet += int'(o_frame_start);
    end
    check("mid_no_frame_start", fs_quiet, 0);
    @(negedge clk);
    check("mid_frame_start", 32'(o_frame_start), 1);

    // Random reset pulses of random length at random raster positions.
    repeat (12) begin
      repeat ($urandom_range(1, 1200)) @(negedge clk);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst_n = 1'b1;
    end
    repeat (700) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
